// File: rtl/crypto_wallet2_led_sequencer.sv
// Avalon-MM LED sequencer: plays up to four programmable LED frames with a
// programmable frame period, falling back to a direct value when idle.
module crypto_wallet2_led_sequencer #(
    parameter int PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  out_port,
    output logic        irq
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    localparam logic [PRESCALE_W-1:0] CNT_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    state_t                state_r, state_nxt_s;
    logic                  enable_r, enable_nxt_s;
    logic                  loop_r, loop_nxt_s;
    logic                  irq_en_r, irq_en_nxt_s;
    logic [1:0]            last_r, last_nxt_s;
    logic                  done_r, done_nxt_s;
    logic [PRESCALE_W-1:0] prescale_r, prescale_nxt_s;
    logic [7:0]            direct_r, direct_nxt_s;
    logic [7:0]            pattern_r [4];
    logic [7:0]            pattern_nxt_s [4];
    logic [1:0]            idx_r, idx_nxt_s;
    logic [PRESCALE_W-1:0] cnt_r, cnt_nxt_s;
    logic [7:0]            out_port_r, out_nxt_s;
    logic                  wr_s;
    logic                  ctrl_wr_s;
    logic                  unused_wdata_s;

    assign wr_s           = chipselect && !write_n;
    assign ctrl_wr_s      = wr_s && (address == 3'd0);
    assign unused_wdata_s = ^writedata[31:8];

    // Register writes, then sequencer next state; frame loads use the post-write
    // pattern/direct values so a write coinciding with a load is displayed at once.
    always_comb begin
        state_nxt_s    = state_r;
        enable_nxt_s   = enable_r;
        loop_nxt_s     = loop_r;
        irq_en_nxt_s   = irq_en_r;
        last_nxt_s     = last_r;
        done_nxt_s     = done_r;
        prescale_nxt_s = prescale_r;
        direct_nxt_s   = direct_r;
        pattern_nxt_s  = pattern_r;
        idx_nxt_s      = idx_r;
        cnt_nxt_s      = cnt_r;
        out_nxt_s      = out_port_r;

        if (wr_s) begin
            case (address)
                3'd0: begin
                    enable_nxt_s = writedata[0];
                    loop_nxt_s   = writedata[1];
                    irq_en_nxt_s = writedata[2];
                    last_nxt_s   = writedata[5:4];
                end
                3'd1: begin
                    if (writedata[1]) begin
                        done_nxt_s = 1'b0;
                    end else begin
                        done_nxt_s = done_r;
                    end
                end
                3'd2:    prescale_nxt_s = writedata[PRESCALE_W-1:0];
                3'd3:    direct_nxt_s   = writedata[7:0];
                default: pattern_nxt_s[address[1:0]] = writedata[7:0];
            endcase
        end else begin
            done_nxt_s = done_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (ctrl_wr_s && writedata[0]) begin
                    state_nxt_s = ST_RUN;
                    idx_nxt_s   = 2'd0;
                    cnt_nxt_s   = '0;
                    out_nxt_s   = pattern_nxt_s[0];
                end else begin
                    out_nxt_s = direct_nxt_s;
                end
            end
            ST_RUN: begin
                if (ctrl_wr_s) begin
                    if (writedata[0]) begin
                        idx_nxt_s = 2'd0;
                        cnt_nxt_s = '0;
                        out_nxt_s = pattern_nxt_s[0];
                    end else begin
                        state_nxt_s = ST_IDLE;
                        out_nxt_s   = direct_nxt_s;
                    end
                end else if (cnt_r >= prescale_r) begin
                    cnt_nxt_s = '0;
                    if (idx_r < last_r) begin
                        idx_nxt_s = idx_r + 2'd1;
                        out_nxt_s = pattern_nxt_s[idx_r + 2'd1];
                    end else if (loop_r) begin
                        idx_nxt_s = 2'd0;
                        out_nxt_s = pattern_nxt_s[0];
                    end else begin
                        // Completion overrides a same-edge done clear.
                        state_nxt_s  = ST_IDLE;
                        enable_nxt_s = 1'b0;
                        done_nxt_s   = 1'b1;
                        out_nxt_s    = direct_nxt_s;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                out_nxt_s   = direct_nxt_s;
            end
        endcase
    end

    // State and register file update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            enable_r   <= 1'b0;
            loop_r     <= 1'b0;
            irq_en_r   <= 1'b0;
            last_r     <= 2'd0;
            done_r     <= 1'b0;
            prescale_r <= '0;
            direct_r   <= 8'h00;
            for (int i = 0; i < 4; i++) begin
                pattern_r[i] <= 8'h00;
            end
            idx_r      <= 2'd0;
            cnt_r      <= '0;
            out_port_r <= 8'h00;
        end else begin
            state_r    <= state_nxt_s;
            enable_r   <= enable_nxt_s;
            loop_r     <= loop_nxt_s;
            irq_en_r   <= irq_en_nxt_s;
            last_r     <= last_nxt_s;
            done_r     <= done_nxt_s;
            prescale_r <= prescale_nxt_s;
            direct_r   <= direct_nxt_s;
            pattern_r  <= pattern_nxt_s;
            idx_r      <= idx_nxt_s;
            cnt_r      <= cnt_nxt_s;
            out_port_r <= out_nxt_s;
        end
    end

    // Zero-wait-state read mux.
    always_comb begin
        case (address)
            3'd0:    readdata = {26'd0, last_r, 1'b0, irq_en_r, loop_r, enable_r};
            3'd1:    readdata = {30'd0, done_r, (state_r == ST_RUN)};
            3'd2:    readdata = {{(32-PRESCALE_W){1'b0}}, prescale_r};
            3'd3:    readdata = {24'd0, direct_r};
            3'd4:    readdata = {24'd0, pattern_r[0]};
            3'd5:    readdata = {24'd0, pattern_r[1]};
            3'd6:    readdata = {24'd0, pattern_r[2]};
            3'd7:    readdata = {24'd0, pattern_r[3]};
            default: readdata = 32'd0;
        endcase
    end

    assign out_port = out_port_r;
    assign irq      = done_r & irq_en_r;

endmodule

// File: tb/tb_crypto_wallet2_led_sequencer.sv
// Directed and randomized bench for the LED sequencer, checked against an
// arithmetic frame-timing model (frame = t / (P+1) mod (L+1)).
module tb_crypto_wallet2_led_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [7:0] pat [4];
    logic [7:0] dir;
    int         p, l;
    bit         lp, ie;

    always #5 clk = ~clk;

    crypto_wallet2_led_sequencer #(.PRESCALE_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .irq        (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        address    = a;
        chipselect = 1'b1;
        #1;
        chk(tag, readdata, exp);
        chipselect = 1'b0;
    endtask

    // Expected LED value t edges after the start edge.
    function automatic logic [7:0] model_out(input int t);
        int total;
        total = (l + 1) * (p + 1);
        if (!lp && t >= total) return dir;
        return pat[(t / (p + 1)) % (l + 1)];
    endfunction

    task automatic set_patterns(input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] c, input logic [7:0] d);
        pat[0] = a; pat[1] = b; pat[2] = c; pat[3] = d;
        for (int i = 0; i < 4; i++) wr(3'(4 + i), {24'd0, pat[i]});
    endtask

    task automatic rand_run();
        int total, n;
        bit done_e, busy_e;
        for (int i = 0; i < 4; i++) begin
            pat[i] = 8'($urandom_range(255, 0));
            wr(3'(4 + i), {24'd0, pat[i]});
        end
        dir = 8'($urandom_range(255, 0));
        wr(3'd3, {24'd0, dir});
        chk("rnd_direct", {24'd0, out_port}, {24'd0, dir});
        p  = int'($urandom_range(4, 0));
        l  = int'($urandom_range(3, 0));
        lp = 1'($urandom_range(1, 0));
        ie = 1'($urandom_range(1, 0));
        wr(3'd2, 32'(p));
        wr(3'd0, 32'((l << 4) | (int'(ie) << 2) | (int'(lp) << 1) | 1));
        total = (l + 1) * (p + 1);
        n = lp ? (2 * total + 1) : (total + 2);
        for (int t = 0; t < n; t++) begin
            done_e = !lp && (t >= total);
            busy_e = lp || (t < total);
            chk("rnd_out", {24'd0, out_port}, {24'd0, model_out(t)});
            chk("rnd_irq", {31'd0, irq}, {31'd0, done_e & ie});
            rd_chk("rnd_status", 3'd1, {30'd0, done_e, busy_e});
            if (t < n - 1) cyc();
        end
        if (lp) begin
            wr(3'd0, 32'd0);
            chk("rnd_abort_out", {24'd0, out_port}, {24'd0, dir});
            rd_chk("rnd_abort_status", 3'd1, 32'd0);
        end else begin
            wr(3'd1, 32'd2);
            rd_chk("rnd_clear_status", 3'd1, 32'd0);
            chk("rnd_clear_irq", {31'd0, irq}, 32'd0);
        end
    endtask

    initial begin
        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 32'd0;
        repeat (2) cyc();
        reset = 1'b0;
        cyc();

        // Reset state
        chk("rst_out", {24'd0, out_port}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        for (int a = 0; a < 8; a++) begin
            rd_chk("rst_read", 3'(a), 32'd0);
            cyc();
        end

        // Direct drive in idle
        dir = 8'hA5;
        wr(3'd3, 32'h0000_00A5);
        chk("direct_out", {24'd0, out_port}, 32'h0000_00A5);

        // One-shot, P=2, L=3
        set_patterns(8'h01, 8'h02, 8'h04, 8'h08);
        p = 2; l = 3; lp = 1'b0; ie = 1'b0;
        wr(3'd2, 32'd2);
        wr(3'd0, 32'h31);
        for (int t = 0; t < 14; t++) begin
            chk("oneshot_out", {24'd0, out_port}, {24'd0, model_out(t)});
            if (t == 11) rd_chk("oneshot_busy", 3'd1, 32'h1);
            if (t == 12) begin
                rd_chk("oneshot_status", 3'd1, 32'h2);
                rd_chk("oneshot_ctrl", 3'd0, 32'h30);
                chk("oneshot_irq", {31'd0, irq}, 32'd0);
            end
            if (t < 13) cyc();
        end
        wr(3'd1, 32'd2);
        rd_chk("oneshot_clear", 3'd1, 32'd0);

        // Looping with irq_en, then abort mid-frame
        lp = 1'b1; ie = 1'b1;
        wr(3'd0, 32'h37);
        for (int t = 0; t < 31; t++) begin
            chk("loop_out", {24'd0, out_port}, {24'd0, model_out(t)});
            chk("loop_irq", {31'd0, irq}, 32'd0);
            if (t % 6 == 0) rd_chk("loop_status", 3'd1, 32'h1);
            if (t < 30) cyc();
        end
        wr(3'd0, 32'd0);
        chk("abort_out", {24'd0, out_port}, 32'h0000_00A5);
        rd_chk("abort_status", 3'd1, 32'd0);
        chk("abort_irq", {31'd0, irq}, 32'd0);

        // P=0, L=0 one-shot with irq; clear on the completion edge loses
        wr(3'd2, 32'd0);
        wr(3'd0, 32'h05);
        chk("short_out", {24'd0, out_port}, 32'h01);
        chk("short_irq_start", {31'd0, irq}, 32'd0);
        wr(3'd1, 32'd2);
        chk("short_irq_set", {31'd0, irq}, 32'd1);
        chk("short_out_done", {24'd0, out_port}, 32'hA5);
        rd_chk("short_set_wins", 3'd1, 32'h2);
        wr(3'd0, 32'h00);
        chk("irq_en_off", {31'd0, irq}, 32'd0);
        wr(3'd0, 32'h04);
        chk("irq_en_on", {31'd0, irq}, 32'd1);
        wr(3'd1, 32'd2);
        chk("irq_cleared", {31'd0, irq}, 32'd0);
        rd_chk("status_cleared", 3'd1, 32'd0);

        // Lowering P mid-frame, pattern write on the advance edge
        wr(3'd2, 32'd100);
        wr(3'd0, 32'h35);
        repeat (49) cyc();
        chk("p100_frame0", {24'd0, out_port}, 32'h01);
        wr(3'd2, 32'd10);
        chk("p_lower_hold", {24'd0, out_port}, 32'h01);
        wr(3'd5, 32'h5A);
        chk("p_lower_advance", {24'd0, out_port}, 32'h5A);
        repeat (10) cyc();
        chk("p10_frame1_end", {24'd0, out_port}, 32'h5A);
        cyc();
        chk("p10_frame2", {24'd0, out_port}, 32'h04);
        rd_chk("p10_busy", 3'd1, 32'h1);

        // Reset mid-run
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("midrst_out", {24'd0, out_port}, 32'd0);
        chk("midrst_irq", {31'd0, irq}, 32'd0);
        rd_chk("midrst_status", 3'd1, 32'd0);
        rd_chk("midrst_ctrl", 3'd0, 32'd0);
        repeat (10) cyc();
        chk("midrst_no_resume_out", {24'd0, out_port}, 32'd0);
        rd_chk("midrst_no_resume", 3'd1, 32'd0);

        // Randomized runs
        repeat (8) rand_run();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/crypto_wallet2_led_sequencer.md
# crypto_wallet2_led_sequencer

Avalon-MM slave that owns the 8-bit LED output and plays a programmable sequence of up to four LED frames with a programmable frame period. It replaces direct software writes to the LED port for status and blink patterns. The Nios loads the frames, period and mode once, then starts the sequence. A completion flag and optional level interrupt report the end of a one-shot run. When no sequence is running, a direct value register drives the LEDs.

## Interface
- PRESCALE_W, 16, width of frame-period register and cycle counter
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- address  in  3  register word index
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe; write accepted when chipselect && !write_n
- writedata  in  32  write data
- readdata  out  32  combinational read mux of addressed register; unused bits 0
- out_port  out  8  registered LED drive
- irq  out  1  level interrupt = done & irq_en

## Operation
Register map (word addresses):
- 0 CONTROL: bit0 enable, bit1 loop, bit2 irq_en, bits[5:4] last frame index L (0..3). Reads back the current values.
- 1 STATUS: bit0 busy (state==RUN, read-only), bit1 done. Writing 1 to bit1 clears done.
- 2 PRESCALE: bits[PRESCALE_W-1:0] P. Each frame lasts P+1 clk cycles.
- 3 DIRECT: bits[7:0], the value driven in IDLE.
- 4..7 PATTERN0..3: bits[7:0], the frame values.

State machine, two states:
- IDLE -> RUN on a CONTROL write with bit0=1: idx<=0, cnt<=0, out_port<=PATTERN0.
- RUN, each cycle:
  - If cnt>=P: cnt<=0 and the frame advances.
  - Otherwise: cnt<=cnt+1.
- Frame advance when idx<L: idx<=idx+1, out_port<=PATTERN[idx+1].
- Frame advance when idx==L and loop=1: idx<=0, out_port<=PATTERN0.
- Frame advance when idx==L and loop=0: state<=IDLE, enable<=0, done<=1, out_port<=DIRECT.
- RUN -> IDLE on a CONTROL write with bit0=0 (abort): out_port<=DIRECT next edge, done unchanged.
- CONTROL write with bit0=1 while RUN restarts from frame 0 with cnt=0.

In IDLE, out_port follows DIRECT. A DIRECT write is visible on out_port after the write edge.

## Timing
- Reset values: out_port=0x00, irq=0. All registers are 0, state=IDLE, idx=0, cnt=0.
- Register write takes effect at the accepting edge. readdata is combinational, with zero wait states.
- Start latency: out_port=PATTERN0 from the edge that accepts the start write.
- Frame k is held exactly P+1 cycles. A one-shot run lasts (L+1)*(P+1) cycles from the start edge to out_port=DIRECT.
- P=0: a new frame every cycle.
- The frame compare uses >=. A PRESCALE write mid-frame that lowers P below cnt ends the current frame on the next cycle, with no wrap.
- PATTERN writes during RUN do not alter the displayed frame. They apply when that index is next loaded, including the edge of the write itself if the load coincides.
- A CONTROL write of L during RUN applies at the next frame advance comparison.
- done: if set (completion) and a clear (STATUS write) occur on the same edge, set wins.
- irq is a level signal. It is combinational from done & irq_en, so it follows an irq_en write with no delay.
- Reset asserted mid-run: the next edge forces all reset values. There is no completion and no irq.

## Test plan
- Reset, then read all addresses: readdata=0, out_port=0x00, irq=0. Write DIRECT=0xA5: out_port=0xA5 one edge later.
- PATTERN0..3=0x01,0x02,0x04,0x08; P=2; CONTROL=0x31 (L=3, one-shot): out_port shows each value for exactly 3 cycles. After 12 cycles out_port=DIRECT, STATUS=0x2, CONTROL bit0=0.
- Same setup with CONTROL=0x37 (loop, irq_en): the sequence repeats 0x01..0x08 indefinitely and done/irq stay 0. Write CONTROL=0x00 mid-frame: out_port=DIRECT next edge, busy=0, done=0.
- One-shot with irq_en=1, L=0, P=0: irq rises 1 cycle after start. Write STATUS=0x2 on the completion edge: done stays 1. A subsequent clear: irq=0.
- P=100 running, cnt≈50: write PRESCALE=10 and the frame advances on the next cycle. Write PATTERN(idx+1) during that same cycle: the new value is displayed.
- Assert reset mid-run with L=3: out_port=0x00, busy=0, done=0, irq=0 after the edge. The sequence does not resume after reset deasserts.
